lsu: RTL

// - Load-store unit for the single-cycle RV32I core. Sits downstream of the decoder and ALU.
// - Consumes the ALU address, rs2 store data, decoder mem_wren and instruction funct3.
// - Holds the data memory plus memory-mapped output and input peripheral registers.
// - Returns load data to the writeback mux (wb_sel = 2'b10).

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_dmem.sv | 28 ++
 rtl/lsu.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit.
// - Memory-map base addresses of the IO registers.
// - Access-size encoding (instruction funct3) and address-region enum.
// - Helpers: address decode and byte-lane merge.
package lsu_pkg;

  localparam logic [31:0] ADDR_LEDR = 32'h1000_7000;
  localparam logic [31:0] ADDR_LEDG = 32'h1000_7010;
  localparam logic [31:0] ADDR_HEXL = 32'h1000_7020;
  localparam logic [31:0] ADDR_HEXH = 32'h1000_7024;
  localparam logic [31:0] ADDR_LCD  = 32'h1000_7030;
  localparam logic [31:0] ADDR_SW   = 32'h1001_7800;
  localparam logic [31:0] ADDR_BTN  = 32'h1001_7810;

  // Seven-segment bytes only carry 7 segment bits; bit 7 of each byte stays 0.
  localparam logic [31:0] HEX_MASK  = 32'h7F7F_7F7F;

  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } lsu_size_e;

  typedef enum {
    REG_LEDR, REG_LEDG, REG_HEXL, REG_HEXH, REG_LCD,
    REG_SW, REG_BTN, REG_DMEM, REG_NONE
  } lsu_region_e;

  // DMEM occupies the bottom 4 * 2**dmem_aw bytes; every address bit above
  // that must be zero, so an access past the top falls through to REG_NONE.
  function automatic lsu_region_e lsu_decode(input logic [31:0] addr,
                                             input int          dmem_aw);
    lsu_region_e r;
    r = REG_NONE;
    if ((addr >> (dmem_aw + 2)) == 32'd0)       r = REG_DMEM;
    else if (addr[31:2] == ADDR_LEDR[31:2])     r = REG_LEDR;
    else if (addr[31:2] == ADDR_LEDG[31:2])     r = REG_LEDG;
    else if (addr[31:2] == ADDR_HEXL[31:2])     r = REG_HEXL;
    else if (addr[31:2] == ADDR_HEXH[31:2])     r = REG_HEXH;
    else if (addr[31:2] == ADDR_LCD[31:2])      r = REG_LCD;
    else if (addr[31:2] == ADDR_SW[31:2])       r = REG_SW;
    else if (addr[31:2] == ADDR_BTN[31:2])      r = REG_BTN;
    return r;
  endfunction

  function automatic logic [31:0] lsu_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Data memory: 2**AW words of 32 bits, split into four byte lanes.
// - i_clk    : write clock
// - i_addr   : word address (shared by read and write)
// - i_we     : per-byte write enables, lane n = bits [8n+7:8n]
// - i_wdata  : write data, already placed in its lanes
// - o_rdata  : asynchronous read of the addressed word
// Contents are not reset.
module lsu_dmem #(
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_we,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [2**AW];

    always_ff @(posedge i_clk) begin
      if (i_we[gi]) mem_q[i_addr] <= i_wdata[gi*8 +: 8];
    end

    assign o_rdata[gi*8 +: 8] = mem_q[i_addr];
  end

endmodule

// File: rtl/lsu.sv
// Load-store unit for the single-cycle RV32I core.
// - i_clk, i_rst_n   : clock, asynchronous active-low reset
// - i_lsu_addr       : byte address from the ALU
// - i_st_data        : store data (rs2)
// - i_lsu_wren       : store enable
// - i_funct3         : access size / signedness
// - o_ld_data        : combinational load result, extended per funct3
// - o_misalign       : current access is misaligned
// - o_io_ledr/ledg/hex/lcd : output peripheral registers
// - i_io_sw, i_io_btn      : asynchronous input pins, synchronized
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_AW  = 11,
  parameter int SYNC_LEN = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_ld_data,
  output logic        o_misalign,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [55:0] o_io_hex,
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn
);

  lsu_region_e region;
  logic        misalign;
  logic [3:0]  be;
  logic [3:0]  store_be;
  logic [31:0] wdata_lane;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_rdata;
  logic [31:0] rword;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  logic [31:0] ledr_q, ledr_d;
  logic [31:0] ledg_q, ledg_d;
  logic [31:0] hexl_q, hexl_d;
  logic [31:0] hexh_q, hexh_d;
  logic [31:0] lcd_q,  lcd_d;

  // {btn, sw}; the last stage is what loads observe.
  logic [35:0] sync_q [SYNC_LEN];
  logic [31:0] sw_sync;
  logic [3:0]  btn_sync;

  assign region = lsu_decode(i_lsu_addr, DMEM_AW);

  // Alignment and store byte lanes. Only B/H/W are legal store sizes, so
  // be stays 0 for every other funct3 and suppresses the store.
  always_comb begin
    misalign   = 1'b0;
    be         = 4'b0000;
    wdata_lane = i_st_data;
    case (i_funct3)
      F3_B: begin
        be         = 4'b0001 << i_lsu_addr[1:0];
        wdata_lane = {4{i_st_data[7:0]}};
      end
      F3_H: begin
        misalign   = i_lsu_addr[0];
        be         = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{i_st_data[15:0]}};
      end
      F3_W: begin
        misalign   = |i_lsu_addr[1:0];
        be         = 4'b1111;
      end
      F3_HU:   misalign = i_lsu_addr[0];
      default: ;
    endcase
  end

  assign o_misalign = misalign;
  assign store_be   = (i_lsu_wren && !misalign) ? be : 4'b0000;

  // Gating with i_rst_n drops a store that coincides with reset.
  assign dmem_we = (region == REG_DMEM && i_rst_n) ? store_be : 4'b0000;

  lsu_dmem #(
    .AW (DMEM_AW)
  ) u_dmem (
    .i_clk   (i_clk),
    .i_addr  (i_lsu_addr[DMEM_AW+1:2]),
    .i_we    (dmem_we),
    .i_wdata (wdata_lane),
    .o_rdata (dmem_rdata)
  );

  // IO register next state
  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    hexl_d = hexl_q;
    hexh_d = hexh_q;
    lcd_d  = lcd_q;
    case (region)
      REG_LEDR: ledr_d = lsu_merge(ledr_q, wdata_lane, store_be);
      REG_LEDG: ledg_d = lsu_merge(ledg_q, wdata_lane, store_be);
      REG_HEXL: hexl_d = lsu_merge(hexl_q, wdata_lane, store_be) & HEX_MASK;
      REG_HEXH: hexh_d = lsu_merge(hexh_q, wdata_lane, store_be) & HEX_MASK;
      REG_LCD:  lcd_d  = lsu_merge(lcd_q,  wdata_lane, store_be);
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q <= '0;
      ledg_q <= '0;
      hexl_q <= '0;
      hexh_q <= '0;
      lcd_q  <= '0;
    end else begin
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
      hexl_q <= hexl_d;
      hexh_q <= hexh_d;
      lcd_q  <= lcd_d;
    end
  end

  // Input synchronizer: a pin change reaches the last stage after SYNC_LEN edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_LEN; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {i_io_btn, i_io_sw};
      for (int i = 1; i < SYNC_LEN; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sw_sync  = sync_q[SYNC_LEN-1][31:0];
  assign btn_sync = sync_q[SYNC_LEN-1][35:32];

  // Load path: pick the region word, then the lane, then extend.
  always_comb begin
    case (region)
      REG_LEDR: rword = ledr_q;
      REG_LEDG: rword = ledg_q;
      REG_HEXL: rword = hexl_q;
      REG_HEXH: rword = hexh_q;
      REG_LCD:  rword = lcd_q;
      REG_SW:   rword = sw_sync;
      REG_BTN:  rword = {28'd0, btn_sync};
      REG_DMEM: rword = dmem_rdata;
      default:  rword = 32'd0;
    endcase
  end

  assign byte_sel = rword[{i_lsu_addr[1:0], 3'b000} +: 8];
  assign half_sel = rword[{i_lsu_addr[1], 4'b0000} +: 16];

  always_comb begin
    o_ld_data = 32'd0;
    if (!misalign) begin
      case (i_funct3)
        F3_B:    o_ld_data = {{24{byte_sel[7]}}, byte_sel};
        F3_H:    o_ld_data = {{16{half_sel[15]}}, half_sel};
        F3_W:    o_ld_data = rword;
        F3_BU:   o_ld_data = {24'd0, byte_sel};
        F3_HU:   o_ld_data = {16'd0, half_sel};
        default: o_ld_data = 32'd0;
      endcase
    end
  end

  // HEXn occupies 7 bits at [7n+6:7n]; hex0-3 come from the low register.
  for (genvar gi = 0; gi < 4; gi++) begin : g_hex
    assign o_io_hex[gi*7 +: 7]      = hexl_q[gi*8 +: 7];
    assign o_io_hex[28 + gi*7 +: 7] = hexh_q[gi*8 +: 7];
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;

endmodule
